fft8_bitrev_reorder: RTL

//  Output-side companion to the streaming 8-point radix-2 SDF FFT. The FFT emits

---
 rtl/fft8_bitrev_reorder_if.sv | 24 ++
 rtl/fft8_bitrev_reorder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fft8_bitrev_reorder_if.sv
// Stream bundle between the FFT output, the bit-reversal reorder buffer and its consumer.
// The slave modport is the reorder block's view; the master modport is the driver/consumer view.
interface fft8_bitrev_reorder_if #(
   parameter int DW = 24
);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_sof;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_sof;
   logic          out_eof;
   logic          sync_err;

   modport slave (
      input  in_valid, in_data, in_sof,
      output out_valid, out_data, out_sof, out_eof, sync_err
   );

   modport master (
      output in_valid, in_data, in_sof,
      input  out_valid, out_data, out_sof, out_eof, sync_err
   );
endinterface

// File: rtl/fft8_bitrev_reorder.sv
// Ping-pong reorder buffer: writes FFT bins at bit-reversed addresses and
// streams each completed frame back out in natural bin order with sof/eof markers.
module fft8_bitrev_reorder #(
   parameter int N     = 8,
   parameter int LOG2N = 3,
   parameter int DW    = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   fft8_bitrev_reorder_if.slave bus
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_READ = 1'b1} rd_state_t;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction

   logic [DW-1:0]    mem_r [2][N];
   logic [LOG2N-1:0] wr_cnt_r;
   logic             wr_bank_r;
   logic [1:0]       bank_full_r;
   logic [1:0]       bank_full_nxt_s;
   logic             sync_err_r;
   logic             wr_restart_s;
   logic             wr_last_s;
   logic [LOG2N-1:0] wr_addr_s;

   rd_state_t        state_r, state_nxt_s;
   logic [LOG2N-1:0] rd_cnt_r, rd_cnt_nxt_s;
   logic             rd_bank_r, rd_bank_nxt_s;
   logic             rd_done_s;

   logic             out_valid_r, out_sof_r, out_eof_r;
   logic [DW-1:0]    out_data_r;

   // A mid-frame sof restarts the frame at slot 0 of the current bank.
   assign wr_restart_s = bus.in_valid & bus.in_sof & (wr_cnt_r != {LOG2N{1'b0}});
   assign wr_last_s    = bus.in_valid & ~wr_restart_s & (wr_cnt_r == LOG2N'(N-1));
   assign wr_addr_s    = wr_restart_s ? {LOG2N{1'b0}} : bitrev(wr_cnt_r);

   // Write-side counter, bank select and sync error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_r   <= {LOG2N{1'b0}};
         wr_bank_r  <= 1'b0;
         sync_err_r <= 1'b0;
      end else begin
         sync_err_r <= wr_restart_s;
         if (bus.in_valid) begin
            if (wr_restart_s) begin
               wr_cnt_r <= LOG2N'(1);
            end else if (wr_last_s) begin
               wr_cnt_r  <= {LOG2N{1'b0}};
               wr_bank_r <= ~wr_bank_r;
            end else begin
               wr_cnt_r <= wr_cnt_r + LOG2N'(1);
            end
         end
      end
   end

   // Frame storage; contents are don't-care until the matching bank_full is set
   always_ff @(posedge clk) begin
      if (bus.in_valid) mem_r[wr_bank_r][wr_addr_s] <= bus.in_data;
   end

   // Reader clear and writer set act on different banks in normal operation
   always_comb begin
      bank_full_nxt_s = bank_full_r;
      if (rd_done_s) bank_full_nxt_s[rd_bank_r] = 1'b0;
      else           bank_full_nxt_s = bank_full_nxt_s;
      if (wr_last_s) bank_full_nxt_s[wr_bank_r] = 1'b1;
      else           bank_full_nxt_s = bank_full_nxt_s;
   end

   // Bank occupancy flags
   always_ff @(posedge clk) begin
      if (rst) bank_full_r <= 2'b00;
      else     bank_full_r <= bank_full_nxt_s;
   end

   // Read FSM next-state logic
   always_comb begin
      state_nxt_s   = state_r;
      rd_cnt_nxt_s  = rd_cnt_r;
      rd_bank_nxt_s = rd_bank_r;
      rd_done_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bank_full_r[rd_bank_r]) begin
               state_nxt_s  = ST_READ;
               rd_cnt_nxt_s = {LOG2N{1'b0}};
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: begin
            rd_cnt_nxt_s = rd_cnt_r + LOG2N'(1);
            if (rd_cnt_r == LOG2N'(N-1)) begin
               rd_done_s     = 1'b1;
               rd_bank_nxt_s = ~rd_bank_r;
               // Stay in READ when the other bank is ready: keeps continuous input gapless
               state_nxt_s   = bank_full_r[~rd_bank_r] ? ST_READ : ST_IDLE;
            end else begin
               state_nxt_s = ST_READ;
            end
         end
         default: begin
            state_nxt_s  = ST_IDLE;
            rd_cnt_nxt_s = {LOG2N{1'b0}};
         end
      endcase
   end

   // Read FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         rd_cnt_r  <= {LOG2N{1'b0}};
         rd_bank_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         rd_cnt_r  <= rd_cnt_nxt_s;
         rd_bank_r <= rd_bank_nxt_s;
      end
   end

   // Registered output stage; out_data holds between frames
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_sof_r   <= 1'b0;
         out_eof_r   <= 1'b0;
         out_data_r  <= {DW{1'b0}};
      end else if (state_r == ST_READ) begin
         out_valid_r <= 1'b1;
         out_sof_r   <= (rd_cnt_r == {LOG2N{1'b0}});
         out_eof_r   <= (rd_cnt_r == LOG2N'(N-1));
         out_data_r  <= mem_r[rd_bank_r][rd_cnt_r];
      end else begin
         out_valid_r <= 1'b0;
         out_sof_r   <= 1'b0;
         out_eof_r   <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_sof   = out_sof_r;
   assign bus.out_eof   = out_eof_r;
   assign bus.sync_err  = sync_err_r;

endmodule
